button_counter: RTL and testbench

BUTTON_COUNTER -- requirements
Module: button_counter

---
 rtl/button_counter.sv | 148 ++++++++++++++
 tb/tb_button_counter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// Two-button up/down counter: each active-low button is synchronized, debounced and
// auto-repeated while held; the 6-bit count wraps modulo 64 and drives active-low LEDs.
module button_counter #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int REPEAT_DELAY    = 13500000,
   parameter int REPEAT_PERIOD   = 2700000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_up_n,
   input  logic       btn_dn_n,
   output logic [5:0] count,
   output logic [5:0] led,
   output logic       up_evt,
   output logic       dn_evt
);

   localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_CYC = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
   localparam int TW = $clog2(MAX_CYC + 1);

   // Timers are compared one short of the target so the transition and pulse land on the target cycle.
   localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
   localparam logic [TW-1:0] ONE      = TW'(1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   // Index 0 is the up button, index 1 the down button.
   logic [1:0]    r_syncMeta;
   logic [1:0]    r_syncOut;
   state_t        r_state [2];
   state_t        w_stateNext [2];
   logic [TW-1:0] r_timer [2];
   logic [TW-1:0] w_timerNext [2];
   logic [1:0]    r_repeating;
   logic [1:0]    w_repeatingNext;
   logic [1:0]    w_evt;
   logic [5:0]    r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_syncMeta <= 2'b11;
         r_syncOut  <= 2'b11;
      end else begin
         r_syncMeta <= {btn_dn_n, btn_up_n};
         r_syncOut  <= r_syncMeta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_state[i] <= IDLE;
            r_timer[i] <= '0;
         end
         r_repeating <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_state[i] <= w_stateNext[i];
            r_timer[i] <= w_timerNext[i];
         end
         r_repeating <= w_repeatingNext;
      end
   end

   // r_repeating selects the first-repeat delay versus the steady repeat period while HELD.
   always_comb begin
      w_stateNext     = r_state;
      w_timerNext     = r_timer;
      w_repeatingNext = r_repeating;
      w_evt           = '0;
      for (int i = 0; i < 2; i++) begin
         case (r_state[i])
            IDLE: begin
               if (!r_syncOut[i]) begin
                  w_stateNext[i] = PRESS_WAIT;
                  w_timerNext[i] = ONE;
               end
            end
            PRESS_WAIT: begin
               if (r_syncOut[i]) begin
                  w_stateNext[i] = IDLE;
                  w_timerNext[i] = '0;
               end else if (r_timer[i] == DEB_LAST) begin
                  w_stateNext[i]     = HELD;
                  w_timerNext[i]     = '0;
                  w_repeatingNext[i] = 1'b0;
                  w_evt[i]           = 1'b1;
               end else begin
                  w_timerNext[i] = r_timer[i] + ONE;
               end
            end
            HELD: begin
               if (r_syncOut[i]) begin
                  w_stateNext[i] = RELEASE_WAIT;
                  w_timerNext[i] = ONE;
               end else if ((!r_repeating[i] && r_timer[i] == DLY_LAST) ||
                            (r_repeating[i] && r_timer[i] == PER_LAST)) begin
                  w_timerNext[i]     = '0;
                  w_repeatingNext[i] = 1'b1;
                  w_evt[i]           = 1'b1;
               end else begin
                  w_timerNext[i] = r_timer[i] + ONE;
               end
            end
            RELEASE_WAIT: begin
               if (!r_syncOut[i]) begin
                  w_stateNext[i]     = HELD;
                  w_timerNext[i]     = '0;
                  w_repeatingNext[i] = 1'b0;
               end else if (r_timer[i] == DEB_LAST) begin
                  w_stateNext[i] = IDLE;
                  w_timerNext[i] = '0;
               end else begin
                  w_timerNext[i] = r_timer[i] + ONE;
               end
            end
            default: begin
               w_stateNext[i] = IDLE;
               w_timerNext[i] = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_evt[0] && !w_evt[1]) begin
         r_count <= r_count + 6'd1;
      end else if (w_evt[1] && !w_evt[0]) begin
         r_count <= r_count - 6'd1;
      end
   end

   assign count  = r_count;
   assign led    = ~r_count;
   assign up_evt = w_evt[0];
   assign dn_evt = w_evt[1];

endmodule

// File: tb/tb_button_counter.sv
// Bench for button_counter: scenario tasks plus a randomized run, each checked cycle by
// cycle against a run-length model of debounce and auto-repeat behaviour.
module tb_button_counter;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_up_n = 1'b1;
   logic       btn_dn_n = 1'b1;
   logic [5:0] count;
   logic [5:0] led;
   logic       up_evt;
   logic       dn_evt;

   int total = 0;
   int bad = 0;

   // Model: accepted level, run of pressed cycles, run of released cycles, cycles since acceptance.
   bit   mAcc [2];
   int   mRun [2];
   int   mRel [2];
   int   mSince [2];
   bit [1:0] mDelay1;
   bit [1:0] mDelay2;
   int   mCount;
   bit   expUp;
   bit   expDn;
   logic [5:0] expCount;
   int   upSeen;
   int   dnSeen;

   button_counter #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_up_n(btn_up_n),
      .btn_dn_n(btn_dn_n),
      .count(count),
      .led(led),
      .up_evt(up_evt),
      .dn_evt(dn_evt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelButton(input int b, input bit p, output bit ev);
      ev = 1'b0;
      if (!mAcc[b]) begin
         mRun[b] = p ? mRun[b] + 1 : 0;
         if (mRun[b] == D) begin
            ev = 1'b1;
            mAcc[b] = 1'b1;
            mRun[b] = 0;
            mRel[b] = 0;
            mSince[b] = 0;
         end
      end else if (!p) begin
         mRel[b]++;
         if (mRel[b] == D) begin
            mAcc[b] = 1'b0;
            mRel[b] = 0;
         end
      end else if (mRel[b] > 0) begin
         mRel[b] = 0;
         mSince[b] = 0;
      end else begin
         mSince[b]++;
         if (mSince[b] == RD || (mSince[b] > RD && (mSince[b] - RD) % RP == 0)) ev = 1'b1;
      end
   endtask

   task automatic modelReset();
      for (int b = 0; b < 2; b++) begin
         mAcc[b] = 1'b0;
         mRun[b] = 0;
         mRel[b] = 0;
         mSince[b] = 0;
      end
      mCount = 0;
      mDelay2 = 2'b00;
      mDelay1 = {~btn_dn_n, ~btn_up_n};
   endtask

   // Advances one clock: computes expectations for the cycle now starting, then drives new levels.
   task automatic applyStimulus(input bit up, input bit dn);
      bit eu, ed;
      @(negedge clk);
      modelButton(0, mDelay2[0], eu);
      modelButton(1, mDelay2[1], ed);
      expUp = eu;
      expDn = ed;
      expCount = 6'(mCount);
      if (eu && !ed) mCount = (mCount + 1) % 64;
      else if (ed && !eu) mCount = (mCount + 63) % 64;
      mDelay2 = mDelay1;
      mDelay1 = {dn, up};
      btn_up_n = ~up;
      btn_dn_n = ~dn;
   endtask

   task automatic doReset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (count !== 6'd0 || led !== 6'b111111 || up_evt !== 1'b0 || dn_evt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_state: got count=%0d led=%b up=%b dn=%b want 0 111111 0 0",
                  count, led, up_evt, dn_evt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b0);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL reset_idle: got up=%b dn=%b count=%0d led=%b want up=%b dn=%b count=%0d",
                     up_evt, dn_evt, count, led, expUp, expDn, expCount);
         end
      end
   endtask

   task automatic test_single_press();
      bit [1:0] seq[$];
      doReset();
      upSeen = 0;
      repeat (8) seq.push_back(2'b01);
      repeat (12) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL single_cycle%0d: got up=%b dn=%b count=%0d led=%b want up=%b dn=%b count=%0d",
                     k, up_evt, dn_evt, count, led, expUp, expDn, expCount);
         end
         upSeen += int'(up_evt);
      end
      total++;
      if (upSeen !== 1) begin
         bad++;
         $display("[TB] FAIL single_events: got %0d want 1", upSeen);
      end
      total++;
      if (count !== 6'd1 || led !== 6'b111110) begin
         bad++;
         $display("[TB] FAIL single_count: got count=%0d led=%b want 1 111110", count, led);
      end
   endtask

   task automatic test_glitch_and_wrap();
      bit [1:0] seq[$];
      doReset();
      dnSeen = 0;
      repeat (2) seq.push_back(2'b10);
      repeat (10) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL glitch_cycle%0d: got up=%b dn=%b count=%0d want up=%b dn=%b count=%0d",
                     k, up_evt, dn_evt, count, expUp, expDn, expCount);
         end
         dnSeen += int'(dn_evt);
      end
      total++;
      if (dnSeen !== 0 || count !== 6'd0) begin
         bad++;
         $display("[TB] FAIL glitch_ignored: got events=%0d count=%0d want 0 0", dnSeen, count);
      end
      seq.delete();
      repeat (6) seq.push_back(2'b10);
      repeat (10) seq.push_back(2'b00);
      repeat (6) seq.push_back(2'b01);
      repeat (10) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL wrap_cycle%0d: got up=%b dn=%b count=%0d want up=%b dn=%b count=%0d",
                     k, up_evt, dn_evt, count, expUp, expDn, expCount);
         end
         dnSeen += int'(dn_evt);
         if (k == 15) begin
            total++;
            if (count !== 6'd63 || dnSeen !== 1) begin
               bad++;
               $display("[TB] FAIL wrap_down: got count=%0d events=%0d want 63 1", count, dnSeen);
            end
         end
      end
      total++;
      if (count !== 6'd0 || led !== 6'b111111) begin
         bad++;
         $display("[TB] FAIL wrap_up: got count=%0d led=%b want 0 111111", count, led);
      end
   endtask

   task automatic test_auto_repeat();
      bit [1:0] seq[$];
      doReset();
      upSeen = 0;
      repeat (40) seq.push_back(2'b01);
      repeat (12) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL repeat_cycle%0d: got up=%b count=%0d want up=%b count=%0d",
                     k, up_evt, count, expUp, expCount);
         end
         upSeen += int'(up_evt);
      end
      total++;
      if (upSeen !== 10 || count !== 6'd10) begin
         bad++;
         $display("[TB] FAIL repeat_total: got events=%0d count=%0d want 10 10", upSeen, count);
      end
   endtask

   task automatic test_both_buttons();
      bit [1:0] seq[$];
      bit together;
      doReset();
      upSeen = 0;
      dnSeen = 0;
      together = 1'b0;
      repeat (6) seq.push_back(2'b11);
      repeat (12) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL both_cycle%0d: got up=%b dn=%b count=%0d want up=%b dn=%b count=%0d",
                     k, up_evt, dn_evt, count, expUp, expDn, expCount);
         end
         upSeen += int'(up_evt);
         dnSeen += int'(dn_evt);
         if (up_evt === 1'b1 && dn_evt === 1'b1) together = 1'b1;
      end
      total++;
      if (!together || upSeen !== 1 || dnSeen !== 1 || count !== 6'd0) begin
         bad++;
         $display("[TB] FAIL both_cancel: got together=%b up=%0d dn=%0d count=%0d want 1 1 1 0",
                  together, upSeen, dnSeen, count);
      end
   endtask

   task automatic test_release_bounce();
      bit [1:0] seq[$];
      doReset();
      upSeen = 0;
      repeat (6) seq.push_back(2'b01);
      repeat (2) seq.push_back(2'b00);
      seq.push_back(2'b01);
      repeat (10) seq.push_back(2'b00);
      repeat (4) seq.push_back(2'b01);
      repeat (10) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL bounce_cycle%0d: got up=%b count=%0d want up=%b count=%0d",
                     k, up_evt, count, expUp, expCount);
         end
         upSeen += int'(up_evt);
         if (k == 18) begin
            total++;
            if (upSeen !== 1 || count !== 6'd1) begin
               bad++;
               $display("[TB] FAIL bounce_no_extra: got events=%0d count=%0d want 1 1", upSeen, count);
            end
         end
      end
      total++;
      if (upSeen !== 2 || count !== 6'd2) begin
         bad++;
         $display("[TB] FAIL bounce_back_idle: got events=%0d count=%0d want 2 2", upSeen, count);
      end
   endtask

   task automatic test_reset_while_held();
      bit [1:0] seq[$];
      int guard;
      doReset();
      guard = 0;
      while (expCount !== 6'd5 && guard < 200) begin
         applyStimulus(1'b1, 1'b0);
         guard++;
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL held_cycle%0d: got up=%b count=%0d want up=%b count=%0d",
                     guard, up_evt, count, expUp, expCount);
         end
      end
      total++;
      if (count !== 6'd5) begin
         bad++;
         $display("[TB] FAIL held_reach5: got count=%0d want 5 within 200 cycles", count);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (count !== 6'd0 || led !== 6'b111111 || up_evt !== 1'b0) begin
         bad++;
         $display("[TB] FAIL held_async_reset: got count=%0d led=%b up=%b want 0 111111 0",
                  count, led, up_evt);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      upSeen = 0;
      repeat (8) seq.push_back(2'b01);
      repeat (12) seq.push_back(2'b00);
      foreach (seq[k]) begin
         applyStimulus(seq[k][0], seq[k][1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL redebounce_cycle%0d: got up=%b count=%0d want up=%b count=%0d",
                     k, up_evt, count, expUp, expCount);
         end
         upSeen += int'(up_evt);
      end
      total++;
      if (upSeen !== 1 || count !== 6'd1) begin
         bad++;
         $display("[TB] FAIL redebounce_once: got events=%0d count=%0d want 1 1", upSeen, count);
      end
   endtask

   task automatic test_random();
      bit [1:0] level;
      int runLeft [2];
      doReset();
      level = 2'b00;
      runLeft[0] = 0;
      runLeft[1] = 0;
      for (int k = 0; k < 700; k++) begin
         for (int b = 0; b < 2; b++) begin
            if (runLeft[b] == 0) begin
               level[b] = ~level[b];
               runLeft[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(3, 30));
            end
            runLeft[b]--;
         end
         applyStimulus(level[0], level[1]);
         total++;
         if ({up_evt, dn_evt, count, led} !== {expUp, expDn, expCount, ~expCount}) begin
            bad++;
            $display("[TB] FAIL random_cycle%0d: got up=%b dn=%b count=%0d led=%b want up=%b dn=%b count=%0d",
                     k, up_evt, dn_evt, count, led, expUp, expDn, expCount);
         end
      end
   endtask

   initial begin
      $display("[TB] starting button_counter bench");
      test_reset();
      test_single_press();
      test_glitch_and_wrap();
      test_auto_repeat();
      test_both_buttons();
      test_release_bounce();
      test_reset_while_held();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
